// File: rtl/imm_encode_pkg.sv
// Shared definitions for the immediate encoder, extender and decoder:
// immediate-type codes, FSM state encodings and the result record.
package imm_encode_pkg;

    // Immediate type selector values
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;
    localparam logic [1:0] IMM_INV = 2'b11;

    // Encoder FSM state encodings
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SEARCH = 2'b01;
    localparam logic [1:0] DONE   = 2'b10;

    // Registered encoder result
    typedef struct packed {
        logic        ok;
        logic [23:0] field;
    } imm_result_t;

    // A branch offset is encodable when word aligned and the top seven
    // bits are a pure sign extension of bit 25.
    function automatic logic br_encodable(input logic [31:0] v);
        return (v[1:0] == 2'b00) && ((v[31:25] == 7'h00) || (v[31:25] == 7'h7f));
    endfunction

endpackage

// File: rtl/imm_rot_check.sv
// Combinational rotation test for data-processing constants: rotates the
// operand left by 2*r and reports whether the result fits in 8 bits.
module imm_rot_check (
    input  logic [31:0] value_i,
    input  logic [3:0]  r_i,
    output logic [7:0]  cand_o,
    output logic        hit_o
);

    logic [63:0] dbl;
    logic [31:0] cand;

    // Rotate-left built from a doubled word so a zero shift needs no special case
    assign dbl    = {value_i, value_i} << {r_i, 1'b0};
    assign cand   = dbl[63:32];
    assign cand_o = cand[7:0];
    assign hit_o  = (cand[31:8] == 24'h000000);

endmodule

// File: rtl/imm_encode.sv
// Multi-cycle immediate encoder: finds the Instr[23:0] immediate field that
// the extender expands back to Value, or reports that none exists.
// Data-processing constants are searched one rotation per cycle.
module imm_encode
    import imm_encode_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  ImmSrc,
    input  logic [31:0] Value,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic [23:0] ImmField
);

    logic [1:0]  state_q, state_d;
    logic [3:0]  r_q, r_d;
    logic [1:0]  src_q, src_d;
    logic [31:0] value_q, value_d;
    imm_result_t res_q, res_d;

    logic [7:0]  cand;
    logic        hit;

    imm_rot_check u_rot_check (
        .value_i (value_q),
        .r_i     (r_q),
        .cand_o  (cand),
        .hit_o   (hit)
    );

    // Next-state, counter and result decision logic
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        src_d   = src_q;
        value_d = value_q;
        res_d   = res_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SEARCH;
                    r_d     = 4'd0;
                    src_d   = ImmSrc;
                    value_d = Value;
                end else begin
                    state_d = IDLE;
                end
            end
            SEARCH: begin
                case (src_q)
                    IMM_DP: begin
                        if (hit) begin
                            res_d.ok    = 1'b1;
                            res_d.field = {12'h000, r_q, cand};
                            state_d     = DONE;
                        end else if (r_q == 4'd15) begin
                            res_d.ok    = 1'b0;
                            res_d.field = 24'h000000;
                            state_d     = DONE;
                        end else begin
                            r_d = r_q + 4'd1;
                        end
                    end
                    IMM_MEM: begin
                        res_d.ok    = (value_q[31:12] == 20'h00000);
                        res_d.field = res_d.ok ? {12'h000, value_q[11:0]} : 24'h000000;
                        state_d     = DONE;
                    end
                    IMM_BR: begin
                        res_d.ok    = br_encodable(value_q);
                        res_d.field = res_d.ok ? value_q[25:2] : 24'h000000;
                        state_d     = DONE;
                    end
                    default: begin
                        res_d.ok    = 1'b0;
                        res_d.field = 24'h000000;
                        state_d     = DONE;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and result registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            r_q     <= 4'd0;
            src_q   <= IMM_DP;
            value_q <= 32'h00000000;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            src_q   <= src_d;
            value_q <= value_d;
            res_q   <= res_d;
        end
    end

    assign busy     = (state_q == SEARCH);
    assign done     = (state_q == DONE);
    assign ok       = res_q.ok;
    assign ImmField = res_q.field;

endmodule

// File: tb/tb_imm_encode.sv
// Self-checking bench for imm_encode: directed cases plus randomized
// requests compared against a range/rotation reference model.
module tb_imm_encode;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  ImmSrc;
    logic [31:0] Value;
    logic        busy;
    logic        done;
    logic        ok;
    logic [23:0] ImmField;

    int          checks = 0;
    int          errors = 0;
    logic        prev_ok = 1'b0;
    logic [23:0] prev_field = 24'h0;

    imm_encode dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .ImmSrc   (ImmSrc),
        .Value    (Value),
        .busy     (busy),
        .done     (done),
        .ok       (ok),
        .ImmField (ImmField)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] v, input int s);
        if (s == 0) return v;
        return (v << s) | (v >> (32 - s));
    endfunction

    // Reference: smallest rotation whose rotated value is below 256; memory
    // offsets below 4096; branch offsets word aligned within +/-2^25.
    task automatic ref_model(input logic [1:0] src, input logic [31:0] v,
                             output logic eok, output logic [23:0] ef, output int elat);
        logic [31:0] c;
        int          sv;
        eok  = 1'b0;
        ef   = 24'h0;
        elat = 1;
        case (src)
            2'b00: begin
                elat = 16;
                for (int r = 0; r < 16; r++) begin
                    c = rol(v, 2 * r);
                    if (!eok && c < 256) begin
                        eok  = 1'b1;
                        ef   = {12'h000, 4'(r), c[7:0]};
                        elat = r + 1;
                    end
                end
            end
            2'b01: begin
                if (v < 4096) begin
                    eok = 1'b1;
                    ef  = {12'h000, v[11:0]};
                end
            end
            2'b10: begin
                sv = signed'(v);
                if ((v % 4 == 0) && sv >= -(1 << 25) && sv < (1 << 25)) begin
                    eok = 1'b1;
                    ef  = v[25:2];
                end
            end
            default: ;
        endcase
    endtask

    // Runs one request from a negedge; optionally pulses a stray start
    // mid-search, and optionally chains the next request into DONE.
    task automatic run_req(input logic [1:0] src, input logic [31:0] val,
                           input bit prelaunched, input int inject,
                           input bit chain, input logic [1:0] nsrc, input logic [31:0] nval);
        logic        eok;
        logic [23:0] ef;
        int          elat;
        int          lat;
        bit          seen;
        ref_model(src, val, eok, ef, elat);
        if (!prelaunched) begin
            start  = 1'b1;
            ImmSrc = src;
            Value  = val;
        end
        seen = 1'b0;
        lat  = -1;
        for (int idx = 1; idx <= 20 && !seen; idx++) begin
            @(negedge clk);
            if (idx == 1) begin
                start = 1'b0;
                check("busy_after_start", {31'b0, busy}, 32'd1);
                check("hold_ok", {31'b0, ok}, {31'b0, prev_ok});
                check("hold_field", {8'b0, ImmField}, {8'b0, prev_field});
            end
            if (inject != 0 && idx == inject) begin
                start  = 1'b1;
                ImmSrc = 2'b01;
                Value  = 32'h00000005;
            end
            if (inject != 0 && idx == inject + 1) begin
                start  = 1'b0;
                ImmSrc = src;
                Value  = val;
            end
            if (done) begin
                seen = 1'b1;
                lat  = idx - 1;
            end
        end
        check("done_seen", {31'b0, seen}, 32'd1);
        check("latency", 32'(lat), 32'(elat));
        check("ok", {31'b0, ok}, {31'b0, eok});
        check("field", {8'b0, ImmField}, {8'b0, ef});
        check("busy_at_done", {31'b0, busy}, 32'd0);
        $display("req src=%b val=%h -> ok=%b field=%h lat=%0d (exp ok=%b field=%h lat=%0d)",
                 src, val, ok, ImmField, lat, eok, ef, elat);
        prev_ok    = eok;
        prev_field = ef;
        if (chain) begin
            start  = 1'b1;
            ImmSrc = nsrc;
            Value  = nval;
        end else begin
            @(negedge clk);
            check("done_one_cycle", {31'b0, done}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [1:0]  s;
        reset_n = 1'b0;
        start   = 1'b0;
        ImmSrc  = 2'b00;
        Value   = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_ok", {31'b0, ok}, 32'd0);
        check("rst_field", {8'b0, ImmField}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_req(2'b00, 32'h000000AB, 0, 0, 0, 2'b00, 32'h0);
        run_req(2'b00, 32'hFF000000, 0, 0, 0, 2'b00, 32'h0);
        run_req(2'b00, 32'h00000102, 0, 0, 0, 2'b00, 32'h0);
        run_req(2'b01, 32'h00000FFF, 0, 0, 0, 2'b00, 32'h0);
        run_req(2'b01, 32'h00001000, 0, 0, 0, 2'b00, 32'h0);
        run_req(2'b10, 32'hFFFFFFFC, 0, 0, 0, 2'b00, 32'h0);
        run_req(2'b10, 32'h01FFFFFC, 0, 0, 0, 2'b00, 32'h0);
        run_req(2'b10, 32'h02000000, 0, 0, 0, 2'b00, 32'h0);
        run_req(2'b10, 32'h00000006, 0, 0, 0, 2'b00, 32'h0);
        run_req(2'b11, 32'h00000001, 0, 0, 0, 2'b00, 32'h0);
        run_req(2'b00, 32'h00003FC0, 0, 0, 0, 2'b00, 32'h0);

        // Stray start during SEARCH is ignored
        run_req(2'b00, 32'h00000102, 0, 5, 0, 2'b00, 32'h0);

        // Back-to-back: start held across DONE
        run_req(2'b01, 32'h00000ABC, 0, 0, 1, 2'b00, 32'hFF000000);
        run_req(2'b00, 32'hFF000000, 1, 0, 1, 2'b10, 32'h00000100);
        run_req(2'b10, 32'h00000100, 1, 0, 0, 2'b00, 32'h0);

        // Reset mid-search at r=7
        run_req(2'b00, 32'h000000AB, 0, 0, 0, 2'b00, 32'h0);
        start  = 1'b1;
        ImmSrc = 2'b00;
        Value  = 32'h00000102;
        for (int idx = 1; idx <= 8; idx++) begin
            @(negedge clk);
            if (idx == 1) start = 1'b0;
        end
        check("pre_reset_busy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_ok", {31'b0, ok}, 32'd0);
        check("mid_rst_field", {8'b0, ImmField}, 32'd0);
        $display("reset asserted mid-search: busy=%b done=%b ok=%b field=%h", busy, done, ok, ImmField);
        repeat (2) @(negedge clk);
        check("rst_hold_done", {31'b0, done}, 32'd0);
        reset_n    = 1'b1;
        prev_ok    = 1'b0;
        prev_field = 24'h0;
        @(negedge clk);
        check("post_rst_done", {31'b0, done}, 32'd0);
        run_req(2'b00, 32'hFF000000, 0, 0, 0, 2'b00, 32'h0);

        // Randomized requests
        for (int n = 0; n < 60; n++) begin
            s = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = rol({24'h0, 8'($urandom)}, int'($urandom_range(0, 31)));
                2: v = 32'($urandom_range(0, 8191));
                default: begin
                    v = $urandom;
                    v = {{6{v[26]}}, v[25:0]};
                    if ($urandom_range(0, 1) == 0) v[1:0] = 2'b00;
                end
            endcase
            run_req(s, v, 0, 0, 0, 2'b00, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_encode.md
# imm_encode

Multi-cycle immediate encoder for the pipelined processor: the inverse of the immediate extender. Given a 32-bit constant and an immediate type, it searches for the instruction immediate field that the extender would expand back to that constant, or reports that none exists. It serves the constant-loading and branch-offset path, for example a literal-pool and assembler-assist unit or self-test logic. Data-processing constants use a sequential rotation search, one rotation per cycle.

## Interface
Parameters:
- None; field widths are fixed by the instruction format.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  request strobe; sampled only when the block is ready (state IDLE or DONE).
- ImmSrc  in  2  immediate type: 00 data-processing, 01 LDR/STR 12-bit, 10 branch, 11 invalid.
- Value  in  32  constant to encode; latched with start.
- busy  out  1  high while in SEARCH.
- done  out  1  one-cycle pulse when a result is valid.
- ok  out  1  result status: 1 means an encoding was found, 0 means the value is not encodable.
- ImmField  out  24  encoded Instr[23:0]; all zeros when ok=0.

## Operation
- **States and transitions**
  - IDLE → SEARCH on start.
  - SEARCH → DONE when a decision is made.
  - DONE → IDLE, or DONE → SEARCH when start is high in the DONE cycle (back-to-back requests).
- **Start while busy:** start is ignored in SEARCH. The latched ImmSrc and Value stay stable.
- **ImmSrc 00 (data-processing):**
  - A 4-bit counter r starts at 0. Each cycle, form cand = Value rotated left by 2r.
  - Hit when cand[31:24] and cand[23:8] are both zero, i.e. cand[31:8]==0.
  - On a hit, ImmField = {12'h000, r[3:0], cand[7:0]} and ok=1.
  - The first (smallest) r that hits wins.
  - No hit through r=15 gives ok=0.
- **ImmSrc 01 (LDR/STR):** ok = (Value[31:12]==0). ImmField = {12'h000, Value[11:0]}.
- **ImmSrc 10 (branch):** ok when Value[1:0]==0 and Value[31:25] are all equal. ImmField = Value[25:2].
- **ImmSrc 11:** ok=0 with no search.
- **Round-trip property:** when ok=1, the extender applied to ImmField returns Value.
  - This holds for types 01 and 10.
  - It holds for type 00 when r=0.
  - For type 00 with r≠0, ROR({24'b0, ImmField[7:0]}, 2·ImmField[11:8]) == Value.
- **Output holding:** ok and ImmField are registered. They hold their value until the next done.

## Timing
- **Reset:** reset_n low, asynchronously: state IDLE, r=0, busy=0, done=0, ok=0, ImmField=0.
- **Edge numbering:** E0 is the edge that samples start. E0 loads the operands and enters SEARCH with r=0.
- **Decision and done:** a decision made while r=k is registered at edge E(k+1). done is high for exactly the cycle after that edge.
- **Latency from E0 to done:**
  - 1 cycle for types 01, 10 and 11.
  - k+1 cycles for a type-00 hit at rotation k.
  - 16 cycles for a type-00 miss.
- **busy** is high from E0 until the decision edge. It is low in DONE.
- **Throughput:** with start held high, a new request enters at the DONE edge, giving one result every latency+1 cycles.
- **Reset mid-SEARCH:** the search aborts immediately and no done is produced. ok and ImmField return to 0.
- **r wrap-around:** r never wraps past 15 within a request. It resets to 0 on every accepted start.

## Structure
- **Shared package (header):**
  - ImmSrc constants IMM_DP=2'b00, IMM_MEM=2'b01, IMM_BR=2'b10.
  - State encodings IDLE, SEARCH, DONE.
  - These are shared with the extender and the decoder.
- **Sub-module imm_rot_check:** combinational. It takes Value and r, and outputs cand[7:0] and hit. The top level holds the FSM, counter and result registers.

## Test plan
- **Data-processing, no rotation:** ImmSrc=00, Value=32'h000000AB → done after 1 cycle, ok=1, ImmField=24'h0000AB.
- **Data-processing, rotated:** ImmSrc=00, Value=32'hFF000000 → hit at r=4, done after 5 cycles, ok=1, ImmField=24'h0004FF. Value=32'h00000102 → ok=0 after 16 cycles.
- **Load/store:** ImmSrc=01, Value=32'h00000FFF → ok=1, ImmField=24'h000FFF. Value=32'h00001000 → ok=0, ImmField=0.
- **Branch:**
  - ImmSrc=10, Value=32'hFFFFFFFC → ok=1, ImmField=24'hFFFFFF.
  - Value=32'h01FFFFFC → ok=1, ImmField=24'h7FFFFF.
  - Value=32'h02000000 → ok=0.
  - Value=32'h00000006 → ok=0.
- **Start during SEARCH and back-to-back:** pulse start in SEARCH → the request is ignored and the result is unchanged. Hold start across DONE → the second request starts with no IDLE cycle.
- **Reset mid-search:** drop reset_n mid-search, at r=7, on Value=32'h00000102 → no done, all outputs 0. A fresh request after reset completes normally.
